idma_obi_write_issuer: RTL and testbench
========================================

# idma_obi_write_issuer

Write-side back end for iDMA transfers whose destination is OBI. It takes legalized write bursts (word-aligned base address, beat count, last flag), pairs each burst with word-aligned data and strobes from the dataflow buffer, and issues one OBI write per beat. It collects the OBI write responses and reports one completion per burst, with error and last flags, to the transfer-completion logic. It is the OBI-write counterpart of the OBI-read / AXI-write legalizer path.

## Interface
- DataWidth, 32, OBI data width in bits; StrbWidth = DataWidth/8, OffsetWidth = $clog2(StrbWidth)
- AddrWidth, 32, byte address width
- MaxOutstanding, 4, maximum granted-but-unresponded OBI beats (≥1)
- NumBursts, 2, maximum bursts in flight, counted from accept until completion handshake (≥1)
- clk_i  in  1  clock
- rst_ni  in  1  reset; asynchronous, active-low
- req_addr_i  in  AddrWidth  burst start address; low OffsetWidth bits are ignored and treated as 0
- req_num_beats_i  in  8  beats minus one (AXI len encoding)
- req_last_i  in  1  burst is the last of its 1D transfer
- req_valid_i / req_ready_o  in/out  1  burst descriptor handshake
- data_i  in  DataWidth  write data, word-aligned
- strb_i  in  StrbWidth  byte enables for data_i
- data_valid_i / data_ready_o  in/out  1  data beat handshake
- obi_req_o  out  1  OBI request
- obi_gnt_i  in  1  OBI grant
- obi_addr_o  out  AddrWidth  word-aligned beat address
- obi_we_o  out  1  constant 1
- obi_be_o  out  StrbWidth  equals strb_i
- obi_wdata_o  out  DataWidth  equals data_i
- obi_rvalid_i  in  1  write response valid (no backpressure)
- obi_err_i  in  1  response error, qualified by obi_rvalid_i
- rsp_valid_o / rsp_ready_i  out/in  1  burst completion handshake
- rsp_err_o  out  1  any beat of this burst returned an error
- rsp_last_o  out  1  copy of req_last_i for this burst

## Operation
- Issue FSM has two states.
  - IDLE: req_ready_o = (inflight_q < NumBursts). On accept, load addr_q = aligned req_addr_i and beats_q = req_num_beats_i. Push {num_beats, last} into the tracking FIFO (depth NumBursts). Increment inflight_q. Go to ISSUE.
  - ISSUE: obi_req_o = data_valid_i & (outstanding_q < MaxOutstanding). data_ready_o = obi_req_o & obi_gnt_i.
  - On each grant: addr_q += StrbWidth (wraps modulo 2^AddrWidth), outstanding_q increments.
  - On a grant when beats_q == 0: return to IDLE. Otherwise decrement beats_q.
- Response side:
  - rcnt_q counts responses against the head entry of the tracking FIFO.
  - err_q is a sticky OR of obi_err_i across the burst's responses.
  - When a response arrives and rcnt_q == head num_beats: push {err_q|obi_err_i, last} into the completion FIFO (depth NumBursts), pop the tracking entry, clear rcnt_q and err_q.
  - Otherwise rcnt_q increments.
  - Every response decrements outstanding_q.
- rsp_* is driven from the completion FIFO head. Each handshake pops one entry and decrements inflight_q.
- Capacity guarantee: inflight_q covers both FIFOs, so an unbackpressurable obi_rvalid_i always finds space. A response with no tracked burst is illegal and is asserted against.
- Simultaneous grant and response: outstanding_q is unchanged. Simultaneous accept and rsp handshake: inflight_q is unchanged.

## Timing
- Reset values:
  - req_ready_o = 1 (after reset, NumBursts ≥ 1)
  - obi_req_o = 0, data_ready_o = 0, rsp_valid_o = 0
  - rsp_err_o = 0, rsp_last_o = 0, obi_addr_o = 0, obi_we_o = 1
  - All counters and FIFOs are empty/zero; FSM is in IDLE.
- Accept to first obi_req_o: 1 cycle, provided data_valid_i is high.
- Throughput: one beat per cycle while obi_gnt_i is held high and outstanding_q < MaxOutstanding.
- obi_req_o depends combinationally on data_valid_i. The upstream stream holds data stable until data_ready_o, so OBI request stability is preserved.
- Last response to rsp_valid_o: 1 cycle (registered completion FIFO).
- A burst of N+1 beats produces exactly one rsp handshake.
- Responses return in issue order.
- Reset mid-burst drops all state. Outstanding OBI responses after reset are the system's responsibility.

## Test plan
- Single-beat burst: addr 0x1003, len 0, strb 0xF, gnt immediate, rvalid one cycle later. Required: obi_addr_o = 0x1000; rsp_valid_o 1 cycle after rvalid with err=0 and last=req_last.
- Four-beat burst at 0x20 with gnt held high. Required: addresses 0x20, 0x24, 0x28, 0x2C on consecutive cycles; exactly one rsp.
- MaxOutstanding=2 with responses withheld. Required: obi_req_o drops after 2 grants; resumes the cycle after the first rvalid.
- Error on beat 2 of 3. Required: rsp_err_o = 1 for that burst; the following burst reports err = 0.
- NumBursts=2 with rsp_ready_i held low. Required: third descriptor stalls (req_ready_o = 0); accepted the cycle after the first rsp handshake.
- Address wrap: burst at 0xFFFFFFFC with len 1. Required: second beat address is 0x00000000.

Source files
------------

// File: rtl/idma_obi_write_issuer_if.sv
// Signal bundle around the OBI write issuer: burst descriptors, write data,
// the OBI write port and the per-burst completion stream.
interface idma_obi_write_issuer_if #(
  parameter int unsigned DataWidth = 32,
  parameter int unsigned AddrWidth = 32
) ();
  localparam int unsigned StrbWidth = DataWidth / 8;

  logic [AddrWidth-1:0] req_addr_i;
  logic [7:0]           req_num_beats_i;
  logic                 req_last_i;
  logic                 req_valid_i;
  logic                 req_ready_o;
  logic [DataWidth-1:0] data_i;
  logic [StrbWidth-1:0] strb_i;
  logic                 data_valid_i;
  logic                 data_ready_o;
  logic                 obi_req_o;
  logic                 obi_gnt_i;
  logic [AddrWidth-1:0] obi_addr_o;
  logic                 obi_we_o;
  logic [StrbWidth-1:0] obi_be_o;
  logic [DataWidth-1:0] obi_wdata_o;
  logic                 obi_rvalid_i;
  logic                 obi_err_i;
  logic                 rsp_valid_o;
  logic                 rsp_ready_i;
  logic                 rsp_err_o;
  logic                 rsp_last_o;

  modport master (
    input  req_addr_i, req_num_beats_i, req_last_i, req_valid_i,
    input  data_i, strb_i, data_valid_i,
    input  obi_gnt_i, obi_rvalid_i, obi_err_i,
    input  rsp_ready_i,
    output req_ready_o, data_ready_o,
    output obi_req_o, obi_addr_o, obi_we_o, obi_be_o, obi_wdata_o,
    output rsp_valid_o, rsp_err_o, rsp_last_o
  );

  modport slave (
    output req_addr_i, req_num_beats_i, req_last_i, req_valid_i,
    output data_i, strb_i, data_valid_i,
    output obi_gnt_i, obi_rvalid_i, obi_err_i,
    output rsp_ready_i,
    input  req_ready_o, data_ready_o,
    input  obi_req_o, obi_addr_o, obi_we_o, obi_be_o, obi_wdata_o,
    input  rsp_valid_o, rsp_err_o, rsp_last_o
  );
endinterface

// File: rtl/idma_obi_write_issuer.sv
// iDMA write back end for OBI destinations: issues one OBI write per beat of each
// legalized burst and reports one completion (err, last) per burst, in order.
module idma_obi_write_issuer #(
  parameter int unsigned DataWidth      = 32,
  parameter int unsigned AddrWidth      = 32,
  parameter int unsigned MaxOutstanding = 4,
  parameter int unsigned NumBursts      = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  idma_obi_write_issuer_if.master bus
);
  localparam int unsigned StrbWidth = DataWidth / 8;
  localparam int unsigned OutWidth  = $clog2(MaxOutstanding + 1);
  localparam int unsigned InfWidth  = $clog2(NumBursts + 1);
  localparam int unsigned PtrWidth  = (NumBursts > 1) ? $clog2(NumBursts) : 1;
  localparam logic [AddrWidth-1:0] AlignMask = ~AddrWidth'(StrbWidth - 1);

  typedef enum logic {ST_IDLE, ST_ISSUE} state_e;
  typedef struct packed { logic [7:0] num_beats; logic last; } trk_t;
  typedef struct packed { logic err; logic last; } cmp_t;

  state_e               r_state;
  logic [AddrWidth-1:0] r_addr;
  logic [7:0]           r_beats;
  logic [OutWidth-1:0]  r_outstanding;
  logic [InfWidth-1:0]  r_inflight;
  trk_t                 r_trk_mem [NumBursts];
  logic [PtrWidth-1:0]  r_trk_wptr;
  logic [PtrWidth-1:0]  r_trk_rptr;
  cmp_t                 r_cmp_mem [NumBursts];
  logic [PtrWidth-1:0]  r_cmp_wptr;
  logic [PtrWidth-1:0]  r_cmp_rptr;
  logic [InfWidth-1:0]  r_cmp_cnt;
  logic [7:0]           r_rcnt;
  logic                 r_err;

  logic w_accept;
  logic w_obi_req;
  logic w_grant;
  logic w_burst_done;
  logic w_rsp_hs;
  trk_t w_trk_head;
  cmp_t w_cmp_head;

  function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] p);
    return (p == PtrWidth'(NumBursts - 1)) ? '0 : p + PtrWidth'(1);
  endfunction

  assign w_trk_head   = r_trk_mem[r_trk_rptr];
  assign w_cmp_head   = r_cmp_mem[r_cmp_rptr];
  assign w_accept     = bus.req_valid_i & bus.req_ready_o;
  assign w_obi_req    = (r_state == ST_ISSUE) && bus.data_valid_i &&
                        (r_outstanding < OutWidth'(MaxOutstanding));
  assign w_grant      = w_obi_req & bus.obi_gnt_i;
  assign w_burst_done = bus.obi_rvalid_i && (r_rcnt == w_trk_head.num_beats);
  assign w_rsp_hs     = bus.rsp_valid_o & bus.rsp_ready_i;

  // inflight spans both FIFOs, so neither can overflow on an unstallable response
  assign bus.req_ready_o  = (r_state == ST_IDLE) && (r_inflight < InfWidth'(NumBursts));
  assign bus.data_ready_o = w_grant;
  assign bus.obi_req_o    = w_obi_req;
  assign bus.obi_addr_o   = r_addr;
  assign bus.obi_we_o     = 1'b1;
  assign bus.obi_be_o     = bus.strb_i;
  assign bus.obi_wdata_o  = bus.data_i;
  assign bus.rsp_valid_o  = (r_cmp_cnt != '0);
  assign bus.rsp_err_o    = bus.rsp_valid_o & w_cmp_head.err;
  assign bus.rsp_last_o   = bus.rsp_valid_o & w_cmp_head.last;

  // Issue FSM: walk the beat addresses of the current burst
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= ST_IDLE;
      r_addr  <= '0;
      r_beats <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_addr  <= bus.req_addr_i & AlignMask;
            r_beats <= bus.req_num_beats_i;
            r_state <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (w_grant) begin
            r_addr <= r_addr + AddrWidth'(StrbWidth);
            if (r_beats == '0) r_state <= ST_IDLE;
            else               r_beats <= r_beats - 8'd1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Tracking FIFO plus per-burst response counting
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(NumBursts); i++) r_trk_mem[i] <= '0;
      r_trk_wptr <= '0;
      r_trk_rptr <= '0;
      r_rcnt     <= '0;
      r_err      <= 1'b0;
    end else begin
      if (w_accept) begin
        r_trk_mem[r_trk_wptr] <= '{num_beats: bus.req_num_beats_i, last: bus.req_last_i};
        r_trk_wptr            <= ptr_inc(r_trk_wptr);
      end
      if (w_burst_done) begin
        r_trk_rptr <= ptr_inc(r_trk_rptr);
        r_rcnt     <= '0;
        r_err      <= 1'b0;
      end else if (bus.obi_rvalid_i) begin
        r_rcnt <= r_rcnt + 8'd1;
        r_err  <= r_err | bus.obi_err_i;
      end
    end
  end

  // Completion FIFO feeding the rsp stream
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(NumBursts); i++) r_cmp_mem[i] <= '0;
      r_cmp_wptr <= '0;
      r_cmp_rptr <= '0;
      r_cmp_cnt  <= '0;
    end else begin
      if (w_burst_done) begin
        r_cmp_mem[r_cmp_wptr] <= '{err: r_err | bus.obi_err_i, last: w_trk_head.last};
        r_cmp_wptr            <= ptr_inc(r_cmp_wptr);
      end
      if (w_rsp_hs) r_cmp_rptr <= ptr_inc(r_cmp_rptr);
      case ({w_burst_done, w_rsp_hs})
        2'b10:   r_cmp_cnt <= r_cmp_cnt + InfWidth'(1);
        2'b01:   r_cmp_cnt <= r_cmp_cnt - InfWidth'(1);
        default: r_cmp_cnt <= r_cmp_cnt;
      endcase
    end
  end

  // Outstanding beats and bursts in flight
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_outstanding <= '0;
      r_inflight    <= '0;
    end else begin
      case ({w_grant, bus.obi_rvalid_i})
        2'b10:   r_outstanding <= r_outstanding + OutWidth'(1);
        2'b01:   r_outstanding <= r_outstanding - OutWidth'(1);
        default: r_outstanding <= r_outstanding;
      endcase
      case ({w_accept, w_rsp_hs})
        2'b10:   r_inflight <= r_inflight + InfWidth'(1);
        2'b01:   r_inflight <= r_inflight - InfWidth'(1);
        default: r_inflight <= r_inflight;
      endcase
    end
  end

  // A response must belong to a tracked burst and a granted beat
  a_rsp_tracked: assert property (@(posedge clk_i) disable iff (!rst_ni)
    bus.obi_rvalid_i |-> ((r_inflight != r_cmp_cnt) && (r_outstanding != '0)));

endmodule

// File: tb/tb_idma_obi_write_issuer.sv
// Bench for idma_obi_write_issuer: directed timing scenarios plus randomized
// traffic checked against a burst-level reference model.
module tb_idma_obi_write_issuer;
  localparam int MaxOut = 2;

  logic clk_i  = 1'b0;
  logic rst_ni = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  idma_obi_write_issuer_if #(.DataWidth(32), .AddrWidth(32)) bus ();

  idma_obi_write_issuer #(
    .DataWidth(32), .AddrWidth(32), .MaxOutstanding(MaxOut), .NumBursts(2)
  ) dut (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .bus   (bus)
  );

  always #5 clk_i = ~clk_i;

  typedef struct { logic [31:0] addr; logic [7:0] len; logic last; } desc_t;
  typedef struct { logic [31:0] addr; logic [31:0] data; logic [3:0] strb; } beat_t;

  desc_t       desc_q[$];
  beat_t       beat_q[$];
  beat_t       data_q[$];
  logic        err_q[$];
  logic [1:0]  exp_rsp_q[$];
  int          due_q[$];
  logic [31:0] obs_addr_q[$];
  int          grant_cyc_q[$];
  int          acc_cyc_q[$];
  logic [1:0]  obs_rsp_q[$];

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    bus.req_addr_i = '0; bus.req_num_beats_i = '0; bus.req_last_i = 1'b0; bus.req_valid_i = 1'b0;
    bus.data_i = '0; bus.strb_i = '0; bus.data_valid_i = 1'b0;
    bus.obi_gnt_i = 1'b0; bus.obi_rvalid_i = 1'b0; bus.obi_err_i = 1'b0; bus.rsp_ready_i = 1'b0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    rst_ni = 1'b0;
    desc_q.delete(); beat_q.delete(); data_q.delete(); err_q.delete(); exp_rsp_q.delete();
    repeat (2) @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
  endtask

  // Reference model: expand a burst into expected beats and its expected completion
  task automatic add_burst(input logic [31:0] addr, input logic [7:0] len, input logic last,
                           input int err_beat);
    desc_t d;
    beat_t b;
    logic  e;
    e = 1'b0;
    d.addr = addr; d.len = len; d.last = last;
    desc_q.push_back(d);
    for (int i = 0; i <= int'(len); i++) begin
      b.addr = (addr & 32'hFFFF_FFFC) + 32'(4 * i);
      b.data = $urandom;
      b.strb = 4'($urandom);
      beat_q.push_back(b);
      data_q.push_back(b);
      err_q.push_back(i == err_beat);
      e = e | (i == err_beat);
    end
    exp_rsp_q.push_back({e, last});
  endtask

  // Plays descriptor source, data source, OBI slave and rsp sink until all completions arrive
  task automatic run_traffic(input int max_cycles, input int gnt_pct, input int rdy_pct,
                             input int max_delay);
    int cyc;
    int out;
    int last_due;
    int extra;
    cyc = 0; out = 0; last_due = 0; extra = 0;
    due_q.delete(); obs_addr_q.delete(); grant_cyc_q.delete(); acc_cyc_q.delete(); obs_rsp_q.delete();
    while (cyc < max_cycles && exp_rsp_q.size() > 0) begin
      bus.req_valid_i = (desc_q.size() > 0);
      if (desc_q.size() > 0) begin
        bus.req_addr_i = desc_q[0].addr; bus.req_num_beats_i = desc_q[0].len; bus.req_last_i = desc_q[0].last;
      end
      bus.data_valid_i = (data_q.size() > 0);
      if (data_q.size() > 0) begin
        bus.data_i = data_q[0].data; bus.strb_i = data_q[0].strb;
      end
      bus.obi_gnt_i    = (int'($urandom_range(99)) < gnt_pct);
      bus.obi_rvalid_i = 1'b0;
      if (due_q.size() > 0) bus.obi_rvalid_i = (due_q[0] <= cyc);
      bus.obi_err_i    = (bus.obi_rvalid_i && err_q.size() > 0) ? err_q[0] : 1'b0;
      bus.rsp_ready_i  = (int'($urandom_range(99)) < rdy_pct);
      @(negedge clk_i);
      n_checks++;
      if (bus.obi_we_o !== 1'b1 || bus.data_ready_o !== (bus.obi_req_o & bus.obi_gnt_i)) begin
        n_errors++;
        $display("FAIL traffic_we_ready cyc %0d: we=%b data_ready=%b req=%b gnt=%b", cyc,
                 bus.obi_we_o, bus.data_ready_o, bus.obi_req_o, bus.obi_gnt_i);
      end
      n_checks++;
      if (bus.obi_req_o === 1'b1 && (out >= MaxOut || bus.data_valid_i !== 1'b1)) begin
        n_errors++;
        $display("FAIL traffic_req_gate cyc %0d: req=1 with outstanding %0d data_valid %b", cyc, out, bus.data_valid_i);
      end
      if (bus.obi_req_o === 1'b1 && bus.obi_gnt_i === 1'b1) begin
        n_checks++;
        if (beat_q.size() == 0) begin
          n_errors++;
          $display("FAIL traffic_spurious_beat cyc %0d: addr %h, no beat expected", cyc, bus.obi_addr_o);
        end else begin
          if (bus.obi_addr_o !== beat_q[0].addr || bus.obi_be_o !== beat_q[0].strb ||
              bus.obi_wdata_o !== beat_q[0].data) begin
            n_errors++;
            $display("FAIL traffic_beat cyc %0d: got addr %h be %h data %h, exp addr %h be %h data %h", cyc,
                     bus.obi_addr_o, bus.obi_be_o, bus.obi_wdata_o, beat_q[0].addr, beat_q[0].strb, beat_q[0].data);
          end
          void'(beat_q.pop_front());
          last_due = (cyc + 1 + int'($urandom_range(max_delay)) > last_due) ?
                     cyc + 1 + int'($urandom_range(max_delay)) : last_due;
          due_q.push_back(last_due);
          out++;
        end
        obs_addr_q.push_back(bus.obi_addr_o);
        grant_cyc_q.push_back(cyc);
      end
      if (bus.obi_rvalid_i) begin
        void'(due_q.pop_front());
        void'(err_q.pop_front());
        out--;
      end
      if (bus.req_valid_i && bus.req_ready_o === 1'b1) begin
        void'(desc_q.pop_front());
        acc_cyc_q.push_back(cyc);
      end
      if (bus.data_valid_i && bus.data_ready_o === 1'b1) void'(data_q.pop_front());
      if (bus.rsp_valid_o === 1'b1 && bus.rsp_ready_i) begin
        n_checks++;
        obs_rsp_q.push_back({bus.rsp_err_o, bus.rsp_last_o});
        if (exp_rsp_q.size() == 0) begin
          n_errors++;
          $display("FAIL traffic_spurious_rsp cyc %0d: got err %b last %b", cyc, bus.rsp_err_o, bus.rsp_last_o);
        end else begin
          if ({bus.rsp_err_o, bus.rsp_last_o} !== exp_rsp_q[0]) begin
            n_errors++;
            $display("FAIL traffic_rsp cyc %0d: got err,last %b, exp %b", cyc, {bus.rsp_err_o, bus.rsp_last_o}, exp_rsp_q[0]);
          end
          void'(exp_rsp_q.pop_front());
        end
      end
      cyc++;
      tick();
    end
    n_checks++;
    if (exp_rsp_q.size() != 0) begin
      n_errors++;
      $display("FAIL traffic_timeout: %0d completions still pending after %0d cycles", exp_rsp_q.size(), cyc);
    end
    idle_inputs();
    bus.rsp_ready_i = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk_i);
      if (bus.rsp_valid_o !== 1'b0) extra++;
      tick();
    end
    n_checks++;
    if (extra != 0) begin
      n_errors++;
      $display("FAIL traffic_extra_rsp: %0d extra rsp cycles, exp 0", extra);
    end
    idle_inputs();
  endtask

  task automatic test_reset();
    apply_reset();
    @(negedge clk_i);
    n_checks++;
    if (bus.req_ready_o !== 1'b1) begin n_errors++; $display("FAIL reset_req_ready: got %b exp 1", bus.req_ready_o); end
    n_checks++;
    if ({bus.obi_req_o, bus.data_ready_o, bus.rsp_valid_o, bus.rsp_err_o, bus.rsp_last_o} !== 5'b0) begin
      n_errors++;
      $display("FAIL reset_outputs: req,dready,rvalid,err,last got %b exp 00000",
               {bus.obi_req_o, bus.data_ready_o, bus.rsp_valid_o, bus.rsp_err_o, bus.rsp_last_o});
    end
    n_checks++;
    if (bus.obi_addr_o !== 32'h0 || bus.obi_we_o !== 1'b1) begin
      n_errors++;
      $display("FAIL reset_addr_we: got addr %h we %b exp 0 1", bus.obi_addr_o, bus.obi_we_o);
    end
  endtask

  task automatic test_single_beat();
    apply_reset();
    bus.req_valid_i = 1'b1; bus.req_addr_i = 32'h1003; bus.req_num_beats_i = 8'd0; bus.req_last_i = 1'b1;
    bus.data_valid_i = 1'b1; bus.data_i = 32'hCAFE_0001; bus.strb_i = 4'hF;
    bus.obi_gnt_i = 1'b1; bus.rsp_ready_i = 1'b1;
    @(negedge clk_i);
    n_checks++;
    if (bus.req_ready_o !== 1'b1 || bus.obi_req_o !== 1'b0) begin
      n_errors++; $display("FAIL single_accept: ready %b req %b exp 1 0", bus.req_ready_o, bus.obi_req_o);
    end
    tick();
    bus.req_valid_i = 1'b0;
    @(negedge clk_i);
    n_checks++;
    if (bus.obi_req_o !== 1'b1 || bus.obi_addr_o !== 32'h1000 || bus.obi_be_o !== 4'hF ||
        bus.obi_wdata_o !== 32'hCAFE_0001 || bus.data_ready_o !== 1'b1) begin
      n_errors++;
      $display("FAIL single_issue: req %b addr %h be %h data %h dready %b exp 1 00001000 f cafe0001 1",
               bus.obi_req_o, bus.obi_addr_o, bus.obi_be_o, bus.obi_wdata_o, bus.data_ready_o);
    end
    tick();
    bus.data_valid_i = 1'b0; bus.obi_gnt_i = 1'b0; bus.obi_rvalid_i = 1'b1; bus.obi_err_i = 1'b0;
    @(negedge clk_i);
    n_checks++;
    if (bus.obi_req_o !== 1'b0 || bus.rsp_valid_o !== 1'b0) begin
      n_errors++; $display("FAIL single_resp_cycle: req %b rsp_valid %b exp 0 0", bus.obi_req_o, bus.rsp_valid_o);
    end
    tick();
    bus.obi_rvalid_i = 1'b0;
    @(negedge clk_i);
    n_checks++;
    if ({bus.rsp_valid_o, bus.rsp_err_o, bus.rsp_last_o} !== 3'b101) begin
      n_errors++;
      $display("FAIL single_rsp: valid,err,last got %b exp 101", {bus.rsp_valid_o, bus.rsp_err_o, bus.rsp_last_o});
    end
    tick();
    @(negedge clk_i);
    n_checks++;
    if (bus.rsp_valid_o !== 1'b0 || bus.req_ready_o !== 1'b1) begin
      n_errors++; $display("FAIL single_after: rsp_valid %b req_ready %b exp 0 1", bus.rsp_valid_o, bus.req_ready_o);
    end
  endtask

  task automatic test_four_beat();
    logic [31:0] exp_addr [4];
    exp_addr = '{32'h20, 32'h24, 32'h28, 32'h2C};
    apply_reset();
    add_burst(32'h20, 8'd3, 1'b1, -1);
    run_traffic(200, 100, 100, 0);
    n_checks++;
    if (grant_cyc_q.size() != 4 || acc_cyc_q.size() != 1) begin
      n_errors++; $display("FAIL four_count: grants %0d accepts %0d exp 4 1", grant_cyc_q.size(), acc_cyc_q.size());
    end else begin
      n_checks++;
      if (grant_cyc_q[0] != acc_cyc_q[0] + 1 || grant_cyc_q[3] != grant_cyc_q[0] + 3) begin
        n_errors++;
        $display("FAIL four_timing: accept %0d first grant %0d last grant %0d, exp first=accept+1 and back-to-back",
                 acc_cyc_q[0], grant_cyc_q[0], grant_cyc_q[3]);
      end
      for (int i = 0; i < 4; i++) begin
        n_checks++;
        if (obs_addr_q[i] !== exp_addr[i]) begin
          n_errors++; $display("FAIL four_addr%0d: got %h exp %h", i, obs_addr_q[i], exp_addr[i]);
        end
      end
    end
    n_checks++;
    if (obs_rsp_q.size() != 1) begin n_errors++; $display("FAIL four_rsp_count: got %0d exp 1", obs_rsp_q.size()); end
  endtask

  task automatic test_outstanding();
    logic exp_req;
    apply_reset();
    bus.req_valid_i = 1'b1; bus.req_addr_i = 32'h40; bus.req_num_beats_i = 8'd3; bus.req_last_i = 1'b0;
    bus.data_valid_i = 1'b1; bus.data_i = $urandom; bus.strb_i = 4'hF; bus.obi_gnt_i = 1'b1;
    tick();
    bus.req_valid_i = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      bus.obi_rvalid_i = (c == 5);
      @(negedge clk_i);
      exp_req = (c <= 2) || (c == 6);
      n_checks++;
      if (bus.obi_req_o !== exp_req) begin
        n_errors++; $display("FAIL outstanding_req_c%0d: got %b exp %b", c, bus.obi_req_o, exp_req);
      end
      if (c == 6) begin
        n_checks++;
        if (bus.obi_addr_o !== 32'h48) begin n_errors++; $display("FAIL outstanding_addr: got %h exp 00000048", bus.obi_addr_o); end
      end
      tick();
    end
  endtask

  task automatic test_error();
    apply_reset();
    add_burst(32'h100, 8'd2, 1'b1, 1);
    add_burst(32'h200, 8'd0, 1'b0, -1);
    run_traffic(300, 100, 100, 1);
    n_checks++;
    if (obs_rsp_q.size() != 2) begin
      n_errors++; $display("FAIL error_rsp_count: got %0d exp 2", obs_rsp_q.size());
    end else begin
      n_checks++;
      if (obs_rsp_q[0] !== 2'b11 || obs_rsp_q[1] !== 2'b00) begin
        n_errors++; $display("FAIL error_flags: got %b %b exp 11 00", obs_rsp_q[0], obs_rsp_q[1]);
      end
    end
  endtask

  task automatic test_backpressure();
    int   acc;
    int   first_hs;
    int   acc3;
    logic gprev;
    acc = 0; first_hs = -1; acc3 = -1; gprev = 1'b0;
    apply_reset();
    bus.req_addr_i = 32'h300; bus.req_num_beats_i = 8'd0; bus.req_last_i = 1'b1;
    bus.data_valid_i = 1'b1; bus.strb_i = 4'hF; bus.obi_gnt_i = 1'b1;
    for (int c = 0; c < 30; c++) begin
      bus.req_valid_i  = (acc < 3);
      bus.obi_rvalid_i = gprev;
      bus.obi_err_i    = 1'b0;
      bus.rsp_ready_i  = (c >= 12);
      bus.data_i       = $urandom;
      @(negedge clk_i);
      if (c == 11) begin
        n_checks++;
        if (bus.req_ready_o !== 1'b0 || acc != 2) begin
          n_errors++; $display("FAIL backpressure_stall: req_ready %b accepted %0d exp 0 2", bus.req_ready_o, acc);
        end
      end
      if (bus.req_valid_i && bus.req_ready_o === 1'b1) begin
        acc++;
        if (acc == 3) acc3 = c;
      end
      if (bus.rsp_valid_o === 1'b1 && bus.rsp_ready_i && first_hs < 0) first_hs = c;
      gprev = bus.obi_req_o & bus.obi_gnt_i;
      tick();
    end
    n_checks++;
    if (first_hs != 12 || acc3 != 13) begin
      n_errors++; $display("FAIL backpressure_release: first rsp hs %0d third accept %0d exp 12 13", first_hs, acc3);
    end
  endtask

  task automatic test_wrap();
    apply_reset();
    add_burst(32'hFFFF_FFFC, 8'd1, 1'b0, -1);
    run_traffic(200, 100, 100, 0);
    n_checks++;
    if (obs_addr_q.size() != 2) begin
      n_errors++; $display("FAIL wrap_count: got %0d beats exp 2", obs_addr_q.size());
    end else if (obs_addr_q[0] !== 32'hFFFF_FFFC || obs_addr_q[1] !== 32'h0) begin
      n_errors++; $display("FAIL wrap_addr: got %h %h exp fffffffc 00000000", obs_addr_q[0], obs_addr_q[1]);
    end
  endtask

  task automatic test_random();
    logic [7:0] len;
    apply_reset();
    for (int b = 0; b < 24; b++) begin
      len = 8'($urandom_range(7));
      add_burst($urandom, len, 1'($urandom), ($urandom_range(3) == 0) ? int'($urandom_range(int'(len))) : -1);
    end
    run_traffic(5000, 60, 50, 4);
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_single_beat();
    test_four_beat();
    test_outstanding();
    test_error();
    test_backpressure();
    test_wrap();
    test_random();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
endmodule
